// File: rtl/instr_encode_loader_if.sv
// Descriptor-in and instruction-memory-write bundle for instr_encode_loader.
// slave is the loader's view; master is the producer/memory side.
interface instr_encode_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic        imem_wr_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;

    modport slave (
        input  in_valid, op, rd, rn, rm, imm, imem_ready,
        output in_ready, imem_wr_en, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, op, rd, rn, rm, imm, imem_ready,
        input  in_ready, imem_wr_en, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes instruction descriptors into 32-bit words and writes them to
// instruction memory, followed by PAD_WORDS NOPs.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_LOAD      | in_ready=1, waiting for a descriptor
// S_WRITE     | encoded word on the write port until imem_ready
// S_PAD       | one cycle to stage the NOP word and pad counter
// S_PAD_WRITE | NOP on the write port, one per imem_ready
// S_DONE      | done=1; start restarts like S_IDLE
module instr_encode_loader #(
    parameter int PAD_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [63:0]           base_addr,
    input  logic [7:0]            len,
    instr_encode_loader_if.slave  bus,
    output logic                  done,
    output logic                  err_op,
    output logic                  err_range
);
    localparam logic [31:0] NOP_WORD = 32'h910003FF;
    localparam int          PCW      = $clog2(PAD_WORDS + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_PAD, S_PAD_WRITE, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [63:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [7:0]     remain_q;
    logic [PCW-1:0] pad_q;
    logic [31:0]    enc_word;
    logic           enc_err_op;
    logic           enc_err_range;

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // Signed range checks: all bits above the field must equal its sign bit.
    always_comb begin
        enc_word      = NOP_WORD;
        enc_err_op    = 1'b0;
        enc_err_range = 1'b0;
        case (bus.op)
            4'd0: enc_word = {6'b000101, bus.imm};
            4'd1: begin
                enc_word      = {10'b1001000100, bus.imm[11:0], bus.rn, bus.rd};
                enc_err_range = |bus.imm[25:12];
            end
            4'd2: enc_word = {11'b10101011000, bus.rm, 6'b000000, bus.rn, bus.rd};
            4'd3: enc_word = {11'b11101011000, bus.rm, 6'b000000, bus.rn, bus.rd};
            4'd4: begin
                enc_word      = {8'b01010100, bus.imm[18:0], 5'b01011};
                enc_err_range = !((&bus.imm[25:18]) || !(|bus.imm[25:18]));
            end
            4'd5: begin
                enc_word      = {8'b10110100, bus.imm[18:0], bus.rd};
                enc_err_range = !((&bus.imm[25:18]) || !(|bus.imm[25:18]));
            end
            4'd6: begin
                enc_word      = {11'b11111000010, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
                enc_err_range = !((&bus.imm[25:8]) || !(|bus.imm[25:8]));
            end
            4'd7: begin
                enc_word      = {11'b11111000000, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
                enc_err_range = !((&bus.imm[25:8]) || !(|bus.imm[25:8]));
            end
            4'd8: begin
                enc_word      = {11'b11010011011, 5'b00000, bus.imm[5:0], bus.rn, bus.rd};
                enc_err_range = |bus.imm[25:6];
            end
            4'd9: begin
                enc_word      = {11'b11010011010, 5'b00000, bus.imm[5:0], bus.rn, bus.rd};
                enc_err_range = |bus.imm[25:6];
            end
            4'd10: enc_word = {11'b10011011000, bus.rm, 6'b011111, bus.rn, bus.rd};
            4'd11: enc_word = NOP_WORD;
            default: enc_err_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (len == 8'd0) ? S_PAD : S_LOAD;
            S_LOAD:         if (bus.in_valid) state_nxt = S_WRITE;
            S_WRITE:        if (bus.imem_ready) state_nxt = (remain_q == 8'd1) ? S_PAD : S_LOAD;
            S_PAD:          state_nxt = (PAD_WORDS == 0) ? S_DONE : S_PAD_WRITE;
            S_PAD_WRITE:    if (bus.imem_ready && pad_q == PCW'(1)) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state == S_LOAD);
        bus.imem_wr_en = (state == S_WRITE) || (state == S_PAD_WRITE);
        done           = (state == S_DONE);
    end

    // remain_q counts down the instructions still to be written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            remain_q  <= '0;
            pad_q     <= '0;
            err_op    <= 1'b0;
            err_range <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remain_q  <= len;
                        err_op    <= 1'b0;
                        err_range <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        wdata_q   <= enc_word;
                        err_op    <= err_op | enc_err_op;
                        err_range <= err_range | enc_err_range;
                    end
                end
                S_WRITE: begin
                    if (bus.imem_ready) begin
                        addr_q   <= addr_q + 64'd4;
                        remain_q <= remain_q - 8'd1;
                    end
                end
                S_PAD: begin
                    wdata_q <= NOP_WORD;
                    pad_q   <= PCW'(PAD_WORDS);
                end
                S_PAD_WRITE: begin
                    if (bus.imem_ready) begin
                        addr_q <= addr_q + 64'd4;
                        pad_q  <= pad_q - PCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: encoding table, hand-written stall/reset
// sequences and randomized loads against an arithmetic reference model.
module tb_instr_encode_loader;
    localparam int PAD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] base_addr = '0;
    logic [7:0]  len = '0;
    logic        done, err_op, err_range;

    instr_encode_loader_if bus ();

    instr_encode_loader #(.PAD_WORDS(PAD)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bus       (bus),
        .done      (done),
        .err_op    (err_op),
        .err_range (err_range)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  d_op [256];
    logic [4:0]  d_rd [256];
    logic [4:0]  d_rn [256];
    logic [4:0]  d_rm [256];
    logic [25:0] d_imm[256];

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rn, rm;
        logic [25:0] imm;
        logic [31:0] word;
        bit          eo, er;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    // Reference: word = opcode constant + field values shifted by multiplication.
    function automatic void ref_enc(input logic [3:0] op, input logic [4:0] rd, rn, rm,
                                    input logic [25:0] imm, output logic [31:0] w,
                                    output bit eo, output bit er);
        longint v, regs, r;
        v    = longint'($signed(imm));
        regs = longint'(rn) * 32 + longint'(rd);
        eo = 0; er = 0;
        case (op)
            4'd0:  r = 64'h14000000 + (v & 64'h3FFFFFF);
            4'd1:  begin er = (v < 0) || (v > 4095); r = 64'h91000000 + (v & 4095) * 1024 + regs; end
            4'd2:  r = 64'hAB000000 + longint'(rm) * 65536 + regs;
            4'd3:  r = 64'hEB000000 + longint'(rm) * 65536 + regs;
            4'd4:  begin er = (v < -262144) || (v > 262143); r = 64'h54000000 + (v & 64'h7FFFF) * 32 + 11; end
            4'd5:  begin er = (v < -262144) || (v > 262143); r = 64'hB4000000 + (v & 64'h7FFFF) * 32 + longint'(rd); end
            4'd6:  begin er = (v < -256) || (v > 255); r = 64'hF8400000 + (v & 511) * 4096 + regs; end
            4'd7:  begin er = (v < -256) || (v > 255); r = 64'hF8000000 + (v & 511) * 4096 + regs; end
            4'd8:  begin er = (v < 0) || (v > 63); r = 64'hD3600000 + (v & 63) * 1024 + regs; end
            4'd9:  begin er = (v < 0) || (v > 63); r = 64'hD3400000 + (v & 63) * 1024 + regs; end
            4'd10: r = 64'h9B000000 + longint'(rm) * 65536 + 31 * 1024 + regs;
            4'd11: r = 64'h910003FF;
            default: begin eo = 1; r = 64'h910003FF; end
        endcase
        w = r[31:0];
    endfunction

    // Runs one complete load and checks every write, flags and counts against the model.
    task automatic run_load(input string nm, input logic [63:0] base, input int n,
                            input bit rnd, output logic [31:0] first_word);
        logic [63:0] got_a[$];
        logic [31:0] got_d[$];
        int idx = 0;
        int cyc = 0;
        bit prev_stall = 0;
        logic [63:0] prev_a = '0;
        logic [31:0] prev_d = '0;
        logic [31:0] w;
        bit eo, er, any_eo = 0, any_er = 0;
        @(negedge clk);
        start = 1; base_addr = base; len = 8'(n); bus.in_valid = 0; bus.imem_ready = 1;
        @(negedge clk);
        check({nm, ".clr_err_op"}, err_op, 0);
        check({nm, ".clr_err_range"}, err_range, 0);
        check({nm, ".done_low"}, done, 0);
        while (!done) begin
            if (cyc >= 3000) begin timeout(nm); break; end
            cyc++;
            start = rnd && ($urandom_range(0, 3) == 0);
            base_addr = {$urandom, $urandom};
            len = 8'($urandom);
            if (idx < n && (!rnd || $urandom_range(0, 2) != 0)) begin
                bus.in_valid = 1;
                bus.op = d_op[idx]; bus.rd = d_rd[idx]; bus.rn = d_rn[idx];
                bus.rm = d_rm[idx]; bus.imm = d_imm[idx];
            end else begin
                bus.in_valid = 0;
                bus.op = 4'($urandom); bus.imm = 26'($urandom);
            end
            bus.imem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (prev_stall) begin
                check({nm, ".hold_wr_en"}, bus.imem_wr_en, 1);
                check({nm, ".hold_addr"}, bus.imem_addr, prev_a);
                check({nm, ".hold_data"}, bus.imem_wdata, prev_d);
            end
            prev_stall = bus.imem_wr_en && !bus.imem_ready;
            prev_a = bus.imem_addr;
            prev_d = bus.imem_wdata;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.imem_wr_en && bus.imem_ready) begin
                got_a.push_back(bus.imem_addr);
                got_d.push_back(bus.imem_wdata);
            end
            @(negedge clk);
        end
        start = 0; bus.in_valid = 0;
        check({nm, ".accepted"}, 64'(idx), 64'(n));
        check({nm, ".n_writes"}, 64'(got_a.size()), 64'(n + PAD));
        for (int i = 0; i < n + PAD; i++) begin
            if (i < n) begin
                ref_enc(d_op[i], d_rd[i], d_rn[i], d_rm[i], d_imm[i], w, eo, er);
                any_eo |= eo; any_er |= er;
            end else begin
                w = 32'h910003FF;
            end
            if (i < got_a.size()) begin
                check($sformatf("%s.addr[%0d]", nm, i), got_a[i], base + 64'(4 * i));
                check($sformatf("%s.data[%0d]", nm, i), got_d[i], w);
            end
        end
        check({nm, ".done"}, done, 1);
        check({nm, ".err_op"}, err_op, any_eo);
        check({nm, ".err_range"}, err_range, any_er);
        first_word = (got_d.size() > 0) ? got_d[0] : 32'hxxxxxxxx;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".in_ready"}, bus.in_ready, 0);
        check({nm, ".wr_en"}, bus.imem_wr_en, 0);
        check({nm, ".addr"}, bus.imem_addr, 0);
        check({nm, ".wdata"}, bus.imem_wdata, 0);
        check({nm, ".done"}, done, 0);
        check({nm, ".err_op"}, err_op, 0);
        check({nm, ".err_range"}, err_range, 0);
    endtask

    vec_t vecs[16];
    logic [31:0] fw;
    int wr_cnt;
    int n_rand;

    initial begin
        vecs[0]  = '{4'd1,  5'd1, 5'd31, 5'd0, 26'd5,        32'h910017E1, 0, 0};
        vecs[1]  = '{4'd0,  5'd0, 5'd0,  5'd0, 26'h3FFFFFF,  32'h17FFFFFF, 0, 0};
        vecs[2]  = '{4'd6,  5'd2, 5'd3,  5'd0, 26'd300,      32'hF852C062, 0, 1};
        vecs[3]  = '{4'd13, 5'd0, 5'd0,  5'd0, 26'd0,        32'h910003FF, 1, 0};
        vecs[4]  = '{4'd2,  5'd3, 5'd4,  5'd5, 26'd0,        32'hAB050083, 0, 0};
        vecs[5]  = '{4'd3,  5'd3, 5'd4,  5'd5, 26'd0,        32'hEB050083, 0, 0};
        vecs[6]  = '{4'd10, 5'd0, 5'd1,  5'd2, 26'd0,        32'h9B027C20, 0, 0};
        vecs[7]  = '{4'd8,  5'd1, 5'd2,  5'd0, 26'd3,        32'hD3600C41, 0, 0};
        vecs[8]  = '{4'd9,  5'd1, 5'd2,  5'd0, 26'd64,       32'hD3400041, 0, 1};
        vecs[9]  = '{4'd4,  5'd0, 5'd0,  5'd0, 26'h3FFFFFE,  32'h54FFFFCB, 0, 0};
        vecs[10] = '{4'd5,  5'd7, 5'd0,  5'd0, 26'd4,        32'hB4000087, 0, 0};
        vecs[11] = '{4'd5,  5'd7, 5'd0,  5'd0, 26'h0040000,  32'hB4800007, 0, 1};
        vecs[12] = '{4'd7,  5'd4, 5'd5,  5'd0, 26'h3FFFF00,  32'hF81000A4, 0, 0};
        vecs[13] = '{4'd1,  5'd0, 5'd0,  5'd0, 26'd4096,     32'h91000000, 0, 1};
        vecs[14] = '{4'd1,  5'd0, 5'd0,  5'd0, 26'h3FFFFFF,  32'h913FFC00, 0, 1};
        vecs[15] = '{4'd11, 5'd9, 5'd9,  5'd9, 26'd77,       32'h910003FF, 0, 0};

        bus.in_valid = 0; bus.op = 0; bus.rd = 0; bus.rn = 0; bus.rm = 0;
        bus.imm = 0; bus.imem_ready = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1;
        @(negedge clk);
        check_all_zero("idle");

        for (int i = 0; i < 16; i++) begin
            d_op[0] = vecs[i].op; d_rd[0] = vecs[i].rd; d_rn[0] = vecs[i].rn;
            d_rm[0] = vecs[i].rm; d_imm[0] = vecs[i].imm;
            run_load($sformatf("vec%0d", i), 64'(i) * 64'h100, 1, 0, fw);
            check($sformatf("vec%0d.word", i), fw, vecs[i].word);
            check($sformatf("vec%0d.eo", i), err_op, vecs[i].eo);
            check($sformatf("vec%0d.er", i), err_range, vecs[i].er);
            if (vecs[i].er) begin
                repeat (3) @(negedge clk);
                check($sformatf("vec%0d.er_sticky", i), err_range, 1);
            end
        end

        run_load("len0", 64'h40, 0, 0, fw);

        // Write stalled for three cycles, then accepted exactly once.
        @(negedge clk);
        start = 1; base_addr = 64'h1000; len = 8'd1; bus.imem_ready = 0;
        @(negedge clk);
        start = 0;
        check("stall.in_ready_load", bus.in_ready, 1);
        bus.in_valid = 1; bus.op = 4'd1; bus.rd = 5'd1; bus.rn = 5'd31; bus.imm = 26'd5;
        @(negedge clk);
        bus.in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d.wr_en", k), bus.imem_wr_en, 1);
            check($sformatf("stall%0d.addr", k), bus.imem_addr, 64'h1000);
            check($sformatf("stall%0d.data", k), bus.imem_wdata, 32'h910017E1);
            check($sformatf("stall%0d.in_ready", k), bus.in_ready, 0);
            @(negedge clk);
        end
        bus.imem_ready = 1;
        #1;
        check("stall.write_cycle", bus.imem_wr_en, 1);
        check("stall.write_addr", bus.imem_addr, 64'h1000);
        @(negedge clk);
        check("stall.single_write", bus.imem_wr_en, 0);
        wr_cnt = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (bus.imem_wr_en && bus.imem_ready) begin
                check($sformatf("stall.pad_addr%0d", wr_cnt), bus.imem_addr, 64'h1004 + 64'(4 * wr_cnt));
                wr_cnt++;
            end
            @(negedge clk);
        end
        if (!done) timeout("stall.done");
        check("stall.pad_count", 64'(wr_cnt), 64'(PAD));

        // Asynchronous reset while a write is pending.
        @(negedge clk);
        start = 1; base_addr = 64'h2000; len = 8'd2; bus.imem_ready = 0;
        @(negedge clk);
        start = 0; bus.in_valid = 1; bus.op = 4'd13;
        @(negedge clk);
        bus.in_valid = 0;
        check("rstmid.wr_en_before", bus.imem_wr_en, 1);
        check("rstmid.err_op_before", err_op, 1);
        #2 reset = 0;
        #1;
        check_all_zero("rstmid");
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_all_zero("rstrel");

        // Randomized loads, including an address that wraps past 2^64.
        for (int t = 0; t < 8; t++) begin
            n_rand = $urandom_range(0, 12);
            for (int i = 0; i < n_rand; i++) begin
                d_op[i] = 4'($urandom); d_rd[i] = 5'($urandom);
                d_rn[i] = 5'($urandom); d_rm[i] = 5'($urandom);
                case ($urandom_range(0, 2))
                    0: d_imm[i] = 26'($urandom_range(0, 300));
                    1: d_imm[i] = 26'(-$urandom_range(0, 300));
                    default: d_imm[i] = 26'($urandom);
                endcase
            end
            run_load($sformatf("rnd%0d", t),
                     (t == 0) ? 64'hFFFF_FFFF_FFFF_FFF4 : {$urandom, $urandom & 32'hFFFF_FFFC},
                     n_rand, 1, fw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
